// File: rtl/sh_wdt_gen_if.sv
// IBUS slave-side bundle for the SH watchdog/interval timer register block.
interface sh_wdt_gen_if;
   logic [27:0] IBUS_A;
   logic [31:0] IBUS_DI;
   logic [31:0] IBUS_DO;
   logic        IBUS_WE;
   logic        IBUS_REQ;
   logic        IBUS_BUSY;
   logic        IBUS_ACT;

   modport master (
      output IBUS_A, IBUS_DI, IBUS_WE, IBUS_REQ,
      input  IBUS_DO, IBUS_BUSY, IBUS_ACT
   );

   modport slave (
      input  IBUS_A, IBUS_DI, IBUS_WE, IBUS_REQ,
      output IBUS_DO, IBUS_BUSY, IBUS_ACT
   );
endinterface

// File: rtl/sh_wdt_gen.sv
// SH-family watchdog / interval timer with window refresh, on the internal IBUS.
// Optional macro SH_WDT_WARN_EN adds the WRN pre-overflow warning flag (read bit 16 at +4).
module sh_wdt_gen #(
   parameter int          CNT_W     = 8,
   parameter logic [27:0] BASE      = 28'h5FFFFB8,
   parameter int          OVF_PULSE = 128,
   parameter int          RES_PULSE = 512
`ifdef SH_WDT_WARN_EN
   ,
   parameter int          WARN_DIST = 16
`endif
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic        RES_N,
   input  logic [7:0]  TICK_CE,
   sh_wdt_gen_if.slave bus,
   output logic        ITI_IRQ,
   output logic        WDTOVF_N,
   output logic        PRES,
   output logic        MRES
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int OVF_W = $clog2(OVF_PULSE + 1);
   localparam int RES_W = $clog2(RES_PULSE + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d, win_q, win_d;
   logic [7:0]       csr_q, csr_d;
   logic             wovf_q, wovf_d, rste_q, rste_d, rsts_q, rsts_d;
   logic             wt_ce_q, wt_ce_d;
   logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
   logic [RES_W-1:0] res_cnt_q, res_cnt_d;
   logic             res_sel_q, res_sel_d;
   logic [31:0]      rd_q, rd_d;

   logic        sel_lo, sel_hi, sel, rst_all, wr, tick, tme, wtit;
   logic        wr_cnt, wr_csr, wr_rst, wr_wovf, wr_win;
   logic        early, ovf_evt, wdt_trig, wrn_flag;
   logic [7:0]  key;
   logic        unused_bus;

   // Block occupies two consecutive 32-bit words starting at BASE.
   assign sel_lo  = (bus.IBUS_A[27:2] == BASE[27:2]);
   assign sel_hi  = (bus.IBUS_A[27:2] == (BASE[27:2] + 26'd1));
   assign sel     = sel_lo | sel_hi;
   assign rst_all = RST | (CE_R & ~RES_N);
   assign key     = bus.IBUS_DI[31:24];
   assign wr      = sel & bus.IBUS_WE & bus.IBUS_REQ & CE_R;
   assign wr_cnt  = wr & sel_lo & (key == 8'h5A);
   assign wr_csr  = wr & sel_lo & (key == 8'hA5);
   assign wr_rst  = wr & sel_hi & (key == 8'h5A);
   assign wr_wovf = wr & sel_hi & (key == 8'hA5);
   assign wr_win  = wr & sel_hi & (key == 8'h3C);
   assign tick    = CE_R & wt_ce_q;
   assign tme     = csr_q[5];
   assign wtit    = csr_q[6];
   assign early    = wr_cnt & csr_q[4] & tme & (cnt_q < win_q);
   assign ovf_evt  = tick & tme & (cnt_q == CNT_MAX);
   assign wdt_trig = wtit & (ovf_evt | early);
   assign unused_bus = ^{bus.IBUS_A[1:0], bus.IBUS_DI[23:8]};

   always_comb begin
      cnt_d     = cnt_q;
      win_d     = win_q;
      csr_d     = csr_q;
      wovf_d    = wovf_q;
      rste_d    = rste_q;
      rsts_d    = rsts_q;
      wt_ce_d   = wt_ce_q;
      ovf_cnt_d = ovf_cnt_q;
      res_cnt_d = res_cnt_q;
      res_sel_d = res_sel_q;
      rd_d      = rd_q;

      if (CE_R) wt_ce_d = TICK_CE[csr_q[2:0]];
      if (tick) cnt_d = tme ? cnt_q + CNT_W'(1) : '0;
      if (wr_cnt && !early) cnt_d = bus.IBUS_DI[CNT_W-1:0];

      // Software writes first; hardware flag events below override them.
      if (wr_csr) begin
         csr_d[7]   = bus.IBUS_DI[7] & csr_q[7];
         csr_d[6:4] = bus.IBUS_DI[6:4];
         csr_d[3]   = bus.IBUS_DI[3] & csr_q[3];
         csr_d[2:0] = bus.IBUS_DI[2:0];
      end
      if (wr_rst) {rste_d, rsts_d} = bus.IBUS_DI[6:5];
      if (wr_wovf && !bus.IBUS_DI[7]) wovf_d = 1'b0;
      if (wr_win) win_d = bus.IBUS_DI[CNT_W-1:0];

      if (early) csr_d[3] = 1'b1;
      if (ovf_evt && !wtit) csr_d[7] = 1'b1;
      if (wdt_trig) begin
         wovf_d = 1'b1;
         csr_d  = 8'h18;
      end

      if (CE_R && ovf_cnt_q != '0) ovf_cnt_d = ovf_cnt_q - OVF_W'(1);
      if (wdt_trig) ovf_cnt_d = OVF_W'(OVF_PULSE);
      if (CE_R && res_cnt_q != '0) res_cnt_d = res_cnt_q - RES_W'(1);
      if (wdt_trig && rste_q) begin
         res_cnt_d = RES_W'(RES_PULSE);
         res_sel_d = rsts_q;
      end

      if (CE_F && sel && !bus.IBUS_WE && bus.IBUS_REQ)
         rd_d = sel_lo ? {wovf_q, rste_q, rsts_q, 5'h1F, csr_q, 16'(cnt_q)}
                       : {15'h0, wrn_flag, 16'(win_q)};
   end

   always_ff @(posedge CLK) begin
      if (rst_all) begin
         cnt_q     <= '0;
         win_q     <= '0;
         csr_q     <= 8'h18;
         wovf_q    <= 1'b0;
         rste_q    <= 1'b0;
         rsts_q    <= 1'b0;
         wt_ce_q   <= 1'b0;
         ovf_cnt_q <= '0;
         res_cnt_q <= '0;
         res_sel_q <= 1'b0;
         rd_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         win_q     <= win_d;
         csr_q     <= csr_d;
         wovf_q    <= wovf_d;
         rste_q    <= rste_d;
         rsts_q    <= rsts_d;
         wt_ce_q   <= wt_ce_d;
         ovf_cnt_q <= ovf_cnt_d;
         res_cnt_q <= res_cnt_d;
         res_sel_q <= res_sel_d;
         rd_q      <= rd_d;
      end
   end

`ifdef SH_WDT_WARN_EN
   localparam logic [CNT_W-1:0] WARN_VAL = CNT_MAX - CNT_W'(WARN_DIST);
   logic wrn_q, wrn_d;

   always_comb begin
      wrn_d = wrn_q;
      if (wr_cnt || (wr_wovf && !bus.IBUS_DI[16])) wrn_d = 1'b0;
      if (tick && tme && !(wr_cnt && !early) && ((cnt_q + CNT_W'(1)) == WARN_VAL))
         wrn_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (rst_all) wrn_q <= 1'b0;
      else         wrn_q <= wrn_d;
   end

   assign wrn_flag = wrn_q;
`else
   assign wrn_flag = 1'b0;
`endif

   assign ITI_IRQ       = csr_q[7] | (csr_q[3] & ~csr_q[6]) | wrn_flag;
   assign WDTOVF_N      = (ovf_cnt_q == '0);
   assign PRES          = (res_cnt_q != '0) & ~res_sel_q;
   assign MRES          = (res_cnt_q != '0) & res_sel_q;
   assign bus.IBUS_DO   = sel ? rd_q : 32'h0;
   assign bus.IBUS_BUSY = 1'b0;
   assign bus.IBUS_ACT  = sel;
endmodule

// File: tb/tb_sh_wdt_gen.sv
// Directed bench for sh_wdt_gen: cycle-level spec model on an 8-bit instance plus literal checks,
// and a 16-bit instance sharing the stimulus for the wide-counter prescaler case.
module tb_sh_wdt_gen;
   localparam logic [27:0] BASE = 28'h5FFFFB8;
   localparam logic [27:0] BASE4 = 28'h5FFFFBC;

   logic        clk = 1'b0;
   logic        rst, ce_r, ce_f, res_n;
   logic [7:0]  tb_tick;
   logic [27:0] tb_a;
   logic [31:0] tb_di;
   logic        tb_we, tb_req;
   logic        iti8, ovfn8, pres8, mres8;
   logic        iti16, ovfn16, pres16, mres16;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   sh_wdt_gen_if bus8();
   sh_wdt_gen_if bus16();

   assign bus8.IBUS_A    = tb_a;
   assign bus8.IBUS_DI   = tb_di;
   assign bus8.IBUS_WE   = tb_we;
   assign bus8.IBUS_REQ  = tb_req;
   assign bus16.IBUS_A   = tb_a;
   assign bus16.IBUS_DI  = tb_di;
   assign bus16.IBUS_WE  = tb_we;
   assign bus16.IBUS_REQ = tb_req;

   sh_wdt_gen #(.CNT_W(8)) u_dut8 (
      .CLK(clk), .RST(rst), .CE_R(ce_r), .CE_F(ce_f), .RES_N(res_n), .TICK_CE(tb_tick),
      .bus(bus8.slave), .ITI_IRQ(iti8), .WDTOVF_N(ovfn8), .PRES(pres8), .MRES(mres8)
   );

   sh_wdt_gen #(.CNT_W(16)) u_dut16 (
      .CLK(clk), .RST(rst), .CE_R(ce_r), .CE_F(ce_f), .RES_N(res_n), .TICK_CE(tb_tick),
      .bus(bus16.slave), .ITI_IRQ(iti16), .WDTOVF_N(ovfn16), .PRES(pres16), .MRES(mres16)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model of the 8-bit instance ----------------
   int          m_cnt, m_win, m_cks, m_ovf_left, m_res_left;
   bit          m_ovf, m_wtit, m_tme, m_wen, m_erly, m_wovf, m_rste, m_rsts, m_tick, m_res_m;
   logic [31:0] m_rd;

   function automatic logic [7:0] m_csr();
      return {m_ovf, m_wtit, m_tme, m_wen, m_erly, 3'(m_cks)};
   endfunction

   task model_reset();
      m_cnt = 0; m_win = 0; m_cks = 0; m_ovf_left = 0; m_res_left = 0;
      m_ovf = 0; m_wtit = 0; m_tme = 0; m_wen = 1; m_erly = 1;
      m_wovf = 0; m_rste = 0; m_rsts = 0; m_tick = 0; m_res_m = 0; m_rd = 32'h0;
   endtask

   always @(posedge clk) begin : model
      bit lo, hi, wr, refresh, early, overflow, trig, wtit0, rste0, rsts0, tick_nxt;
      logic [7:0] key;
      lo = (tb_a[27:2] == BASE[27:2]);
      hi = (tb_a[27:2] == BASE4[27:2]);
      if (rst || (ce_r && !res_n)) begin
         model_reset();
      end else begin
         if (ce_f && (lo || hi) && tb_req && !tb_we)
            m_rd = lo ? {m_wovf, m_rste, m_rsts, 5'h1F, m_csr(), 8'h00, 8'(m_cnt)}
                      : {24'h0, 8'(m_win)};
         if (ce_r) begin
            key      = tb_di[31:24];
            wr       = (lo || hi) && tb_we && tb_req;
            refresh  = wr && lo && key == 8'h5A;
            early    = refresh && m_wen && m_tme && (m_cnt < m_win);
            overflow = m_tick && m_tme && (m_cnt == 255);
            wtit0 = m_wtit; rste0 = m_rste; rsts0 = m_rsts;
            trig     = wtit0 && (overflow || early);
            tick_nxt = tb_tick[m_cks];
            if (refresh && !early) m_cnt = int'(tb_di[7:0]);
            else if (m_tick) m_cnt = m_tme ? (m_cnt + 1) % 256 : 0;
            if (wr && lo && key == 8'hA5) begin
               m_wtit = tb_di[6]; m_tme = tb_di[5]; m_wen = tb_di[4]; m_cks = int'(tb_di[2:0]);
               if (!tb_di[7]) m_ovf = 0;
               if (!tb_di[3]) m_erly = 0;
            end
            if (wr && hi && key == 8'h5A) begin m_rste = tb_di[6]; m_rsts = tb_di[5]; end
            if (wr && hi && key == 8'hA5 && !tb_di[7]) m_wovf = 0;
            if (wr && hi && key == 8'h3C) m_win = int'(tb_di[7:0]);
            if (early) m_erly = 1;
            if (overflow && !wtit0) m_ovf = 1;
            if (trig) begin
               m_wovf = 1;
               m_ovf = 0; m_wtit = 0; m_tme = 0; m_wen = 1; m_erly = 1; m_cks = 0;
            end
            if (trig) m_ovf_left = 128;
            else if (m_ovf_left > 0) m_ovf_left--;
            if (trig && rste0) begin m_res_left = 512; m_res_m = rsts0; end
            else if (m_res_left > 0) m_res_left--;
            m_tick = tick_nxt;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         bit sel_now;
         sel_now = (tb_a[27:2] == BASE[27:2]) || (tb_a[27:2] == BASE4[27:2]);
         chk("m_iti", 32'(iti8), 32'(m_ovf | (m_erly & ~m_wtit)));
         chk("m_wdtovf_n", 32'(ovfn8), 32'(m_ovf_left == 0));
         chk("m_pres", 32'(pres8), 32'(m_res_left > 0 && !m_res_m));
         chk("m_mres", 32'(mres8), 32'(m_res_left > 0 && m_res_m));
         chk("m_do", bus8.IBUS_DO, sel_now ? m_rd : 32'h0);
         chk("m_act", 32'(bus8.IBUS_ACT), 32'(sel_now));
         chk("m_busy", 32'(bus8.IBUS_BUSY), 32'h0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [27:0] a, input logic [31:0] d);
      tb_a = a; tb_di = d; tb_we = 1'b1;
      cyc(1);
      tb_we = 1'b0; tb_a = BASE; tb_di = 32'h0;
   endtask

   initial begin
      int n, n_ovf, n_pres, n_mres;
      rst = 1'b1; ce_r = 1'b1; ce_f = 1'b1; res_n = 1'b1; tb_tick = 8'h00;
      tb_a = BASE; tb_di = 32'h0; tb_we = 1'b0; tb_req = 1'b1;
      cyc(2);
      cmp_en = 1'b1;
      chk("rst_wdtovf_n", 32'(ovfn8), 32'h1);
      chk("rst_pres_mres", {30'h0, pres8, mres8}, 32'h0);
      chk("rst_do", bus8.IBUS_DO, 32'h0);
      chk("rst_iti", 32'(iti8), 32'h1);
      rst = 1'b0;
      cyc(1);
      chk("rst_read0", bus8.IBUS_DO, 32'h1F18_0000);

      // bad keys leave everything at reset values
      bus_wr(BASE, 32'h00FF_FFFF);
      bus_wr(BASE4, 32'h00FF_FFFF);
      cyc(1);
      chk("badkey_read0", bus8.IBUS_DO, 32'h1F18_0000);
      tb_a = BASE4;
      cyc(1);
      chk("badkey_read4", bus8.IBUS_DO, 32'h0);
      chk("badkey_act4", 32'(bus8.IBUS_ACT), 32'h1);
      tb_a = BASE;

      // interval mode overflow
      bus_wr(BASE, 32'hA500_0020);
      tb_tick = 8'h01;
      n = 0;
      while (!iti8 && n <= 400) begin cyc(1); n++; end
      chk("itv_cycles_to_ovf", n, 257);
      tb_tick = 8'h00;
      cyc(1);
      chk("itv_read_ovf", bus8.IBUS_DO, 32'h1FA0_0000);
      bus_wr(BASE, 32'hA500_0000);
      chk("itv_ovf_clear_iti", 32'(iti8), 32'h0);

      // watchdog mode overflow with power-on reset request
      bus_wr(BASE4, 32'h5A00_0040);
      bus_wr(BASE, 32'hA500_0060);
      bus_wr(BASE, 32'h5A00_00FE);
      tb_tick = 8'h01;
      cyc(3);
      tb_tick = 8'h00;
      chk("wd_trig_ovfn", 32'(ovfn8), 32'h0);
      chk("wd_trig_pres", 32'(pres8), 32'h1);
      n_ovf = 0; n_pres = 0; n_mres = 0;
      for (int i = 0; i < 600; i++) begin
         n_ovf += int'(!ovfn8); n_pres += int'(pres8); n_mres += int'(mres8);
         cyc(1);
      end
      chk("wd_ovf_width", n_ovf, 128);
      chk("wd_pres_width", n_pres, 512);
      chk("wd_mres_width", n_mres, 0);
      chk("wd_read0", bus8.IBUS_DO, 32'hDF18_0000);

      // window: early refresh triggers, late refresh loads
      bus_wr(BASE4, 32'h3C00_0080);
      bus_wr(BASE4, 32'h5A00_0060);
      bus_wr(BASE, 32'hA500_0020);
      bus_wr(BASE, 32'h5A00_0040);
      bus_wr(BASE, 32'hA500_0070);
      bus_wr(BASE, 32'h5A00_0011);
      chk("win_early_ovfn", 32'(ovfn8), 32'h0);
      chk("win_early_mres", {30'h0, pres8, mres8}, 32'h1);
      cyc(1);
      chk("win_early_read0", bus8.IBUS_DO, 32'hFF18_0040);
      cyc(520);
      bus_wr(BASE, 32'hA500_0020);
      bus_wr(BASE, 32'h5A00_0090);
      bus_wr(BASE, 32'hA500_0070);
      bus_wr(BASE, 32'h5A00_0012);
      chk("win_ok_ovfn", 32'(ovfn8), 32'h1);
      cyc(1);
      chk("win_ok_read0", bus8.IBUS_DO, 32'hFF70_0012);
      chk("win_ok_iti", 32'(iti8), 32'h0);

      // reset in the middle of a pulse
      bus_wr(BASE, 32'h5A00_0000);
      cyc(5);
      chk("rstmid_pre_ovfn", 32'(ovfn8), 32'h0);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("rstmid_ovfn", 32'(ovfn8), 32'h1);
      chk("rstmid_res", {30'h0, pres8, mres8}, 32'h0);
      cyc(1);
      chk("rstmid_read0", bus8.IBUS_DO, 32'h1F18_0000);

      // CE_R gating of writes and of the soft reset
      ce_r = 1'b0;
      bus_wr(BASE, 32'hA500_0020);
      cyc(1);
      chk("cer_gate_read0", bus8.IBUS_DO, 32'h1F18_0000);
      ce_r = 1'b1;
      bus_wr(BASE, 32'hA500_0020);
      ce_r = 1'b0; res_n = 1'b0;
      cyc(1);
      ce_r = 1'b1; res_n = 1'b1;
      cyc(1);
      chk("resn_gated_read0", bus8.IBUS_DO, 32'h1F20_0000);
      res_n = 1'b0;
      cyc(1);
      res_n = 1'b1;
      chk("resn_do", bus8.IBUS_DO, 32'h0);
      cyc(1);
      chk("resn_read0", bus8.IBUS_DO, 32'h1F18_0000);

      // 16-bit counter on prescaler tap 3
      bus_wr(BASE, 32'hA500_0023);
      bus_wr(BASE, 32'h5A00_FFF0);
      for (int i = 0; i < 16; i++) begin
         tb_tick = 8'h08;
         cyc(1);
         if (i == 1)  chk("w16_first_tick", bus16.IBUS_DO, 32'h1F23_FFF1);
         if (i == 15) chk("w16_at_max", bus16.IBUS_DO, 32'h1F23_FFFF);
         if (i == 15) chk("w16_no_irq", 32'(iti16), 32'h0);
         tb_tick = 8'h01;
         cyc(1);
         if (i == 0) chk("w16_latency", bus16.IBUS_DO, 32'h1F23_FFF0);
      end
      tb_tick = 8'h00;
      cyc(1);
      chk("w16_wrap_read0", bus16.IBUS_DO, 32'h1FA3_0000);
      chk("w16_wrap_iti", 32'(iti16), 32'h1);
      chk("w16_ovfn", 32'(ovfn16), 32'h1);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
